rob_recovery_ctrl: RTL
======================

// Module: rob_recovery_ctrl
// PURPOSE
//  Recovery sequencer behind the ROB retire ports. Per cycle it decides which retiring
//  ways actually commit to architectural state. On a retiring mispredicted branch
//  (precise_state_enable) it runs squash -> map restore -> fetch redirect, stalling
//  dispatch meanwhile. On a retiring halt it freezes the pipeline permanently.
// PARAMETERS
//  WAYS            2   retire width (matches SUPERSCALAR_WAYS)
//  PC_W            32  PC width
//  RESTORE_CYCLES  4   cycles to copy the arch map into the spec map (>=1)
// PORTS
//  clock             in   1           rising-edge clock
//  reset             in   1           synchronous, active-high
//  retire_valid      in   WAYS        ROB retire slot i holds a retiring entry
//  retire_precise    in   WAYS        slot i is a mispredicted branch / precise event
//  retire_halt       in   WAYS        slot i is a halt
//  retire_target_pc  in   WAYS*PC_W   correct-path PC for slot i
//  fetch_ready       in   1           fetch accepts a redirect this cycle
//  retire_commit     out  WAYS        slot i commits (arch map / free list update)
//  squash            out  1           flush ROB, RS, FU, free-list tail
//  restore_en        out  1           map-table restore step active
//  restore_cnt       out  clog2(RESTORE_CYCLES) (min 1)   current restore step
//  fetch_redirect    out  1           redirect request to fetch
//  redirect_pc       out  PC_W        redirect target
//  dispatch_stall    out  1           block dispatch into the ROB
//  halted            out  1           processor halted
// BEHAVIOUR
//  States: IDLE, SQUASH, RESTORE, REDIRECT, HALTED. Registered state, counter, target PC.
//  Reset (at any point, including mid-sequence): state=IDLE, cnt=0, pc_q=0.
//   All outputs are 0 in IDLE with no event pending.
//  IDLE:
//   k = lowest index with retire_valid & (retire_precise | retire_halt).
//   No such k: retire_commit = retire_valid.
//   Otherwise: retire_commit[j] = retire_valid[j] for j<=k, 0 for j>k. Younger ways are
//    dropped; they are squashed, never committed.
//   retire_halt[k] set (halt wins over precise): next=HALTED.
//   Else retire_precise[k]: pc_q <= retire_target_pc[k]; next=SQUASH.
//   retire_commit is combinational from the inputs, same cycle (0 latency).
//  SQUASH: squash=1 for exactly 1 cycle. cnt<=0. next=RESTORE.
//  RESTORE: restore_en=1, restore_cnt=cnt. cnt increments every cycle.
//   When cnt==RESTORE_CYCLES-1: next=REDIRECT, cnt<=0.
//  REDIRECT: fetch_redirect=1, redirect_pc=pc_q.
//   Hold state while fetch_ready=0. fetch_ready=1 -> IDLE next cycle.
//  HALTED: halted=1 and dispatch_stall=1, sticky until reset. No squash or redirect.
//  dispatch_stall=1 in SQUASH, RESTORE, REDIRECT and HALTED; also combinationally in IDLE
//   when an event k is detected.
//  Outside IDLE: retire_commit=0 and all retire_* inputs are ignored.
//  redirect_pc=0 whenever fetch_redirect=0. restore_cnt=0 whenever restore_en=0.
//  Total bubble for a mispredict with fetch_ready=1:
//   1 (SQUASH) + RESTORE_CYCLES + 1 (REDIRECT) cycles after the retire cycle.
//  Assertions: at most one of squash/restore_en/fetch_redirect high per cycle;
//   halted implies all others 0 except dispatch_stall.
// TESTING
//  T1 valid=11, precise=00, halt=00 for 3 cycles -> commit=11 each cycle,
//   stall=0, state stays IDLE.
//  T2 valid=11, precise=01, pc0=0x100 -> commit=01 same cycle; squash=1 at +1;
//   restore_en=1 with cnt 0..3 at +2..+5; redirect=1, pc=0x100 at +6; IDLE at +7.
//  T3 as T2 but fetch_ready=0 for 3 cycles during REDIRECT -> redirect stays high with
//   pc held for 4 cycles; stall stays high until the cycle after the accept.
//  T4 valid=11, precise=10, halt=01 -> commit=01, halted=1 from next cycle onward,
//   squash never asserts; later precise inputs are ignored.
//  T5 reset asserted during RESTORE at cnt=2 -> next cycle all outputs 0, state IDLE;
//   a new precise retire restarts the full sequence from cnt=0.
//  T6 valid=10, precise=10, pc1=0x2A0 -> commit=10; redirect_pc=0x2A0 in REDIRECT.

Source files
------------

// File: rtl/rob_recovery_ctrl.sv
// Retire-commit gating and mispredict/halt recovery sequencer: squash -> map restore -> fetch redirect.
// retire_commit is 0-latency combinational; the recovery bubble is 1 + RESTORE_CYCLES + 1 cycles, and REDIRECT holds until fetch_ready.
module rob_recovery_ctrl #(
  parameter int WAYS           = 2,
  parameter int PC_W           = 32,
  parameter int RESTORE_CYCLES = 4,
  localparam int CNT_W = (RESTORE_CYCLES > 1) ? $clog2(RESTORE_CYCLES) : 1,
  localparam int KW    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WAYS-1:0]      retire_valid,
  input  logic [WAYS-1:0]      retire_precise,
  input  logic [WAYS-1:0]      retire_halt,
  input  logic [WAYS*PC_W-1:0] retire_target_pc,
  input  logic                 fetch_ready,
  output logic [WAYS-1:0]      retire_commit,
  output logic                 squash,
  output logic                 restore_en,
  output logic [CNT_W-1:0]     restore_cnt,
  output logic                 fetch_redirect,
  output logic [PC_W-1:0]      redirect_pc,
  output logic                 dispatch_stall,
  output logic                 halted
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SQUASH   = 3'd1,
    RESTORE  = 3'd2,
    REDIRECT = 3'd3,
    HALTED   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PC_W-1:0]   pc_q, pc_nxt;
  logic              found;
  logic [KW-1:0]     k;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pc_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pc_q  <= pc_nxt;
    end
  end

  // Oldest retiring slot carrying an event; everything younger is dropped.
  always_comb begin
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (!found && retire_valid[i] && (retire_precise[i] || retire_halt[i])) begin
        found = 1'b1;
        k     = KW'(i);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    pc_nxt         = pc_q;
    retire_commit  = '0;
    squash         = 1'b0;
    restore_en     = 1'b0;
    restore_cnt    = '0;
    fetch_redirect = 1'b0;
    redirect_pc    = '0;
    dispatch_stall = 1'b0;
    halted         = 1'b0;
    unique case (state)
      IDLE: begin
        if (!found) begin
          retire_commit = retire_valid;
        end else begin
          for (int j = 0; j < WAYS; j++)
            retire_commit[j] = retire_valid[j] && (KW'(j) <= k);
          dispatch_stall = 1'b1;
          if (retire_halt[k]) begin
            state_nxt = HALTED;
          end else begin
            pc_nxt    = retire_target_pc[k*PC_W +: PC_W];
            state_nxt = SQUASH;
          end
        end
      end
      SQUASH: begin
        squash         = 1'b1;
        dispatch_stall = 1'b1;
        cnt_nxt        = '0;
        state_nxt      = RESTORE;
      end
      RESTORE: begin
        restore_en     = 1'b1;
        restore_cnt    = cnt;
        dispatch_stall = 1'b1;
        if (cnt == CNT_W'(RESTORE_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = REDIRECT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      REDIRECT: begin
        fetch_redirect = 1'b1;
        redirect_pc    = pc_q;
        dispatch_stall = 1'b1;
        if (fetch_ready)
          state_nxt = IDLE;
      end
      HALTED: begin
        halted         = 1'b1;
        dispatch_stall = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  a_onehot_phase : assert property (@(posedge clock) disable iff (reset)
    $onehot0({squash, restore_en, fetch_redirect}));
  a_halt_quiet : assert property (@(posedge clock) disable iff (reset)
    halted |-> (!squash && !restore_en && !fetch_redirect && retire_commit == '0 && dispatch_stall));

endmodule
